input_debouncer: RTL and testbench
==================================

// Module: input_debouncer
// PURPOSE
//   Per-channel synchroniser and debouncer for board buttons and switches.
//   Sits directly upstream of the gpio block: db_out drives gpio in_ports.
//   Also produces one-cycle rise/fall pulses and sticky per-channel event flags
//   for software polling or interrupt use.
//   Removes contact bounce and metastability before gpio samples its inputs.
// PARAMETERS
//   NUM_CH         9        number of input channels
//   STABLE_CYCLES  1000000  consecutive stable cycles needed to accept a change (10 ms @ 100 MHz); >= 2
//   CNT_W          20       counter width; must hold STABLE_CYCLES-1
// PORTS
//   clk            in   1       system clock
//   arst           in   1       asynchronous reset, active-high
//   raw_in         in   NUM_CH  raw asynchronous pad inputs
//   bypass         in   1       1: skip debounce filter (synchroniser still used)
//   event_clr      in   NUM_CH  per-channel clear for event_pending
//   db_out         out  NUM_CH  debounced level; feeds gpio in_ports
//   rise_pulse     out  NUM_CH  1-cycle pulse when db_out[i] goes 0->1
//   fall_pulse     out  NUM_CH  1-cycle pulse when db_out[i] goes 1->0
//   event_pending  out  NUM_CH  sticky flag: edge seen since last clear
//   any_event      out  1       OR-reduction of event_pending (registered)
// BEHAVIOUR
//   Reset (async, arst=1)
//     - All state is cleared immediately, independent of clk: sync flops,
//       counters, db_out, pulses, event_pending and any_event all go to 0.
//     - Reset mid-count abandons the count.
//     - After arst deasserts, a pad held at 1 is accepted per the normal rule.
//   Synchroniser
//     - Two flops per channel: raw_in -> s1 -> s2. Filter logic uses only s2.
//   Filter (per channel i, bypass=0)
//     - s2 == db_out[i]: cnt[i] <= 0. Any bounce restarts the count.
//     - s2 != db_out[i] and cnt[i] <  STABLE_CYCLES-1: cnt[i] <= cnt[i]+1.
//     - s2 != db_out[i] and cnt[i] == STABLE_CYCLES-1: db_out[i] <= s2, cnt[i] <= 0.
//     - The counter saturates by construction and never wraps.
//     - Latency: a clean raw change, held, appears on db_out exactly
//       2+STABLE_CYCLES clk edges after the first edge that samples it.
//     - A pulse shorter than STABLE_CYCLES cycles (after sync) never reaches db_out.
//   Bypass (bypass=1)
//     - db_out[i] <= s2 every cycle. Counters are held at 0.
//     - Edge pulses and event flags still operate normally.
//     - Toggling bypass mid-count: the count is discarded. No spurious edge is
//       generated unless db_out actually changes.
//   Edge pulses
//     - Registered, high for exactly one cycle, in the cycle after db_out changes
//       (compare db_out against its delayed copy).
//     - rise_pulse and fall_pulse are never both high for the same channel.
//   Event flags
//     - event_pending[i] is set by rise_pulse[i] | fall_pulse[i].
//     - event_pending[i] is cleared by event_clr[i].
//     - Set and clear in the same cycle: set wins, so no event is lost.
//     - event_clr on a clear flag has no effect.
//     - any_event is registered: it lags event_pending by one cycle.
//   Channels are fully independent. Simultaneous changes on several channels
//   are each handled in parallel, with no arbitration.
// TESTING (bench uses STABLE_CYCLES=4, NUM_CH=9)
//   1. Reset: arst=1 with raw_in=9'h1FF -> all outputs 0.
//      Release arst, hold raw_in -> db_out=9'h1FF after 6 edges.
//      rise_pulse=9'h1FF for exactly 1 cycle. event_pending=9'h1FF.
//   2. Bounce: raw_in[0] toggles 1,0,1,0 at 1-cycle spacing, then holds 1 ->
//      db_out[0] rises only 6 cycles after the final 0->1.
//      Exactly one rise_pulse[0] is seen.
//   3. Glitch: raw_in[3] high for 3 cycles then low -> db_out[3] stays 0.
//      No pulse. event_pending[3] stays 0.
//   4. Clear race: with event_pending[2]=1, assert event_clr[2] in the same cycle
//      as a new fall_pulse[2] -> event_pending[2] remains 1.
//      A later clear with no edge -> 0; any_event drops 1 cycle after that.
//   5. Bypass: bypass=1, raw_in[5] 0->1 -> db_out[5]=1 after 3 edges,
//      with one rise_pulse[5].
//      A 1-cycle raw glitch passes through with a rise and a fall pulse.
//   6. Async reset mid-count: arst pulsed between clk edges while cnt[1]=2 ->
//      outputs 0 before the next edge. Count restarts from 0 after release.

Source files
------------

// File: rtl/input_debouncer.sv
// input_debouncer: per-channel 2-flop synchroniser, stable-count debounce filter,
// registered rise/fall pulses and sticky event flags.
module input_debouncer #(
    parameter int NUM_CH        = 9,
    parameter int STABLE_CYCLES = 1000000,
    parameter int CNT_W         = 20
) (
    input  logic              clk,
    input  logic              arst,
    input  logic [NUM_CH-1:0] raw_in,
    input  logic              bypass,
    input  logic [NUM_CH-1:0] event_clr,
    output logic [NUM_CH-1:0] db_out,
    output logic [NUM_CH-1:0] rise_pulse,
    output logic [NUM_CH-1:0] fall_pulse,
    output logic [NUM_CH-1:0] event_pending,
    output logic              any_event
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);

    logic [NUM_CH-1:0] s1, s2, db_d, db_n;
    logic [CNT_W-1:0]  cnt   [NUM_CH];
    logic [CNT_W-1:0]  cnt_n [NUM_CH];

    // A change is accepted on the STABLE_CYCLES-th consecutive disagreeing sample.
    always_comb begin
        db_n  = db_out;
        cnt_n = cnt;
        for (int i = 0; i < NUM_CH; i++) begin
            cnt_n[i] = (bypass || s2[i] == db_out[i] || cnt[i] == LAST) ? '0 : cnt[i] + 1'b1;
            db_n[i]  = (bypass || (s2[i] != db_out[i] && cnt[i] == LAST)) ? s2[i] : db_out[i];
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            s1            <= '0;
            s2            <= '0;
            db_out        <= '0;
            db_d          <= '0;
            cnt           <= '{default: '0};
            rise_pulse    <= '0;
            fall_pulse    <= '0;
            event_pending <= '0;
            any_event     <= 1'b0;
        end else begin
            s1            <= raw_in;
            s2            <= s1;
            db_out        <= db_n;
            cnt           <= cnt_n;
            db_d          <= db_out;
            rise_pulse    <= db_out & ~db_d;
            fall_pulse    <= ~db_out & db_d;
            // Set beats clear so an edge coinciding with a clear is not lost.
            event_pending <= (event_pending & ~event_clr) | rise_pulse | fall_pulse;
            any_event     <= |event_pending;
        end
    end
endmodule

// File: tb/tb_input_debouncer.sv
// tb_input_debouncer: directed and random stimulus against a sliding-window reference model.
module tb_input_debouncer;
    localparam int N = 9;
    localparam int S = 4;

    logic         clk = 1'b0;
    logic         arst;
    logic [N-1:0] raw_in, event_clr;
    logic         bypass;
    logic [N-1:0] db_out, rise_pulse, fall_pulse, event_pending;
    logic         any_event;

    int total = 0;
    int bad   = 0;

    // Reference model state: s2 history window instead of a counter.
    logic [N-1:0] m_s1, m_s2, m_db, m_dq, m_rise, m_fall, m_ep;
    logic         m_any;
    logic [N-1:0] hs2 [S];
    logic         hby [S];
    int           hn;

    input_debouncer #(.NUM_CH(N), .STABLE_CYCLES(S), .CNT_W(2)) dut (
        .clk(clk), .arst(arst), .raw_in(raw_in), .bypass(bypass), .event_clr(event_clr),
        .db_out(db_out), .rise_pulse(rise_pulse), .fall_pulse(fall_pulse),
        .event_pending(event_pending), .any_event(any_event)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        {m_s1, m_s2, m_db, m_dq, m_rise, m_fall, m_ep} = '0;
        m_any = 1'b0;
        hn = 0;
        for (int k = 0; k < S; k++) begin
            hs2[k] = '0;
            hby[k] = 1'b0;
        end
    endtask

    // One clock edge of the model: accept a change only if the last S
    // filtered (non-bypass) s2 samples all disagree with the current level.
    task automatic m_edge();
        logic [N-1:0] ndb;
        logic         ok;
        if (arst) begin
            m_reset();
            return;
        end
        for (int k = S - 1; k > 0; k--) begin
            hs2[k] = hs2[k-1];
            hby[k] = hby[k-1];
        end
        hs2[0] = m_s2;
        hby[0] = bypass;
        hn = (hn < S) ? hn + 1 : S;
        ndb = m_db;
        if (bypass) ndb = m_s2;
        else
            for (int c = 0; c < N; c++) begin
                ok = (hn == S);
                for (int k = 0; k < S; k++)
                    if (hby[k] || hs2[k][c] == m_db[c]) ok = 1'b0;
                if (ok) ndb[c] = ~m_db[c];
            end
        m_any  = |m_ep;
        m_ep   = (m_ep & ~event_clr) | m_rise | m_fall;
        m_rise = m_db & ~m_dq;
        m_fall = ~m_db & m_dq;
        m_dq   = m_db;
        m_db   = ndb;
        m_s2   = m_s1;
        m_s1   = raw_in;
    endtask

    task automatic tick();
        @(posedge clk);
        m_edge();
        #1;
        chk("db_out", db_out, m_db);
        chk("rise_pulse", rise_pulse, m_rise);
        chk("fall_pulse", fall_pulse, m_fall);
        chk("event_pending", event_pending, m_ep);
        chk("any_event", {8'b0, any_event}, {8'b0, m_any});
    endtask

    initial begin
        int n, rises, falls;
        logic found;
        m_reset();
        arst = 1'b1; raw_in = '1; bypass = 1'b0; event_clr = '0;

        // 1. reset then power-up acceptance of pads held high
        repeat (3) tick();
        chk("reset_db", db_out, '0);
        arst = 1'b0;
        repeat (5) tick();
        chk("pre_accept", db_out, '0);
        tick();
        chk("accept_6", db_out, 9'h1FF);
        tick();
        chk("rise_all", rise_pulse, 9'h1FF);
        tick();
        chk("rise_once", rise_pulse, '0);
        chk("ep_all", event_pending, 9'h1FF);

        // settle everything low and clear flags
        raw_in = '0;
        repeat (10) tick();
        event_clr = '1;
        tick();
        event_clr = '0;
        tick();

        // 2. bounce on channel 0
        rises = 0;
        for (int k = 0; k < 4; k++) begin
            raw_in[0] = ~k[0];
            tick();
            rises += int'(rise_pulse[0]);
        end
        raw_in[0] = 1'b1;
        n = 0;
        found = 1'b0;
        for (int k = 1; k <= 20 && !found; k++) begin
            tick();
            rises += int'(rise_pulse[0]);
            if (db_out[0]) begin
                found = 1'b1;
                n = k;
            end
        end
        chk("bounce_lat", 9'(n), 9'd6);
        repeat (6) begin
            tick();
            rises += int'(rise_pulse[0]);
        end
        chk("bounce_rises", 9'(rises), 9'd1);

        // 3. three-cycle glitch on channel 3 is filtered
        raw_in[3] = 1'b1;
        repeat (3) tick();
        raw_in[3] = 1'b0;
        repeat (8) tick();
        chk("glitch_db", {8'b0, db_out[3]}, 9'd0);
        chk("glitch_ep", {8'b0, event_pending[3]}, 9'd0);

        // 4. clear racing a new fall edge on channel 2
        raw_in[2] = 1'b1;
        repeat (10) tick();
        chk("ep2_set", {8'b0, event_pending[2]}, 9'd1);
        raw_in[2] = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            tick();
            found = fall_pulse[2];
        end
        chk("race_seen", {8'b0, found}, 9'd1);
        event_clr = 9'h004;
        tick();
        chk("race_set_wins", {8'b0, event_pending[2]}, 9'd1);
        event_clr = '0;
        tick();
        event_clr = '1;
        tick();
        event_clr = '0;
        chk("clr_ep", event_pending, '0);
        chk("any_lag", {8'b0, any_event}, 9'd1);
        tick();
        chk("any_drop", {8'b0, any_event}, 9'd0);

        // 5. bypass path
        bypass = 1'b1;
        raw_in[5] = 1'b1;
        repeat (2) tick();
        chk("byp_early", {8'b0, db_out[5]}, 9'd0);
        tick();
        chk("byp_3", {8'b0, db_out[5]}, 9'd1);
        repeat (3) tick();
        raw_in[5] = 1'b0;
        tick();
        raw_in[5] = 1'b1;
        rises = 0;
        falls = 0;
        repeat (6) begin
            tick();
            rises += int'(rise_pulse[5]);
            falls += int'(fall_pulse[5]);
        end
        chk("byp_glitch_r", 9'(rises), 9'd1);
        chk("byp_glitch_f", 9'(falls), 9'd1);
        bypass = 1'b0;

        // 6. async reset in the middle of a count on channel 1
        raw_in[1] = 1'b1;
        repeat (4) tick();
        #1 arst = 1'b1;
        m_reset();
        #1;
        chk("arst_db", db_out, '0);
        chk("arst_ep", event_pending, '0);
        chk("arst_any", {8'b0, any_event}, 9'd0);
        arst = 1'b0;
        repeat (5) tick();
        chk("restart_hold", {8'b0, db_out[1]}, 9'd0);
        tick();
        chk("restart_acc", {8'b0, db_out[1]}, 9'd1);

        // random phase
        for (int k = 0; k < 800; k++) begin
            if ($urandom_range(3) == 0) raw_in[$urandom_range(N - 1)] ^= 1'b1;
            if ($urandom_range(63) == 0) bypass = ~bypass;
            event_clr = N'($urandom & $urandom & $urandom);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
